div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative 32-bit signed/unsigned divider in the execute stage. Consumes the registered ALU opcode
//  from the decode/execute boundary, recognises `EXE_DIV_OP / `EXE_DIVU_OP and computes quotient and
//  remainder one bit per cycle. Stalls the pipeline while busy and delivers {hi,lo} to the HI/LO register.
// PARAMETERS
//  DATA_W   32   operand/result width; iteration count = DATA_W, counter width = $clog2(DATA_W)+1
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  rst         in   1       synchronous, active-high reset
//  aluopE      in   8       execute-stage opcode (defines.vh encodings)
//  srcaE       in   DATA_W  dividend (rs)
//  srcbE       in   DATA_W  divisor (rt)
//  annulE      in   1       flush/exception: abandon current division
//  stall_ext   in   1       other stall holding the E stage (e.g. memory wait)
//  stall_div   out  1       hold F/D/E stages; feeds hazard unit
//  hilo_we     out  1       one-cycle write strobe for HI/LO
//  hi_o        out  DATA_W  remainder
//  lo_o        out  DATA_W  quotient
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. On rst: state IDLE, counter 0, all regs 0,
//    stall_div=0, hilo_we=0, hi_o=lo_o=0.
//  - is_div = (aluopE==`EXE_DIV_OP)|(aluopE==`EXE_DIVU_OP).
//  - FSM IDLE/BUSY/DONE:
//    IDLE: if is_div & ~annulE -> latch |srcaE|,|srcbE| (abs only for DIV), sign flags
//      (q_neg = a[31]^b[31], r_neg = a[31]; both 0 for DIVU), counter=0, -> BUSY.
//      Divisor==0: -> DONE directly, lo=32'hFFFF_FFFF, hi=srcaE (raw, no sign fix); no exception.
//    BUSY: restoring step per cycle: {rem,quo}<<1; if rem>=divisor rem-=divisor, quo[0]=1.
//      counter++; after DATA_W steps -> DONE with sign-corrected results registered.
//    DONE: results held on hi_o/lo_o; hilo_we = ~stall_ext; -> IDLE when ~stall_ext, else stay.
//  - stall_div (combinational) = (IDLE & is_div & ~annulE) | BUSY. Low in DONE so E advances;
//    the instruction leaves E in the same cycle hilo_we fires, so no re-trigger.
//  - Latency: issue cycle + 32 BUSY cycles; hilo_we in cycle 33 after issue (stall_ext=0).
//  - Sign correction: lo = q_neg ? -quo : quo; hi = r_neg ? -rem : rem (remainder takes dividend sign).
//    -2^31 / -1 (DIV): lo=32'h8000_0000, hi=0 (wrap, no trap).
//  - annulE has priority in every state: next state IDLE, hilo_we=0 that cycle, stall_div=0 when
//    annulE in IDLE; partial results discarded. rst mid-operation identical to annul plus output clear.
//  - Non-div opcodes in IDLE: no state change, outputs stable. hi_o/lo_o retain last result.
//  - hilo_we never asserts outside DONE; never twice for one division.
// STRUCTURE
//  - defines.vh: existing `EXE_DIV_OP/`EXE_DIVU_OP; add DIV_IDLE/DIV_BUSY/DIV_DONE state codes.
//  - Sub-module div_core: unsigned restoring step datapath (rem/quo/divisor regs, counter, done flag);
//    div_unit holds FSM, sign handling, stall/handshake logic.
// TESTING
//  - DIV 7/2 -> stall_div high 33 cycles incl. issue, then hilo_we=1 one cycle, lo=3, hi=1.
//  - DIV -7/2 (0xFFFFFFF9/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU same operands -> lo=0x7FFFFFFC, hi=1.
//  - DIVU 0xFFFFFFFF/0 -> DONE next cycle, lo=0xFFFFFFFF, hi=0xFFFFFFFF; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  - annulE at BUSY cycle 10 -> IDLE next cycle, stall_div=0, no hilo_we; following DIV 100/7 -> lo=14, hi=2.
//  - stall_ext=1 for 5 cycles in DONE -> hilo_we=0 while held, single 1-cycle pulse on release, no restart.
//  - rst asserted mid-BUSY -> all outputs 0 next cycle; back-to-back DIV,DIVU both produce correct results.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared opcode encodings, FSM state codes and sign helper for the execute-stage divider.
package div_unit_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = $clog2(DIV_W) + 1;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [DIV_W-1:0] neg_if(input logic n, input logic [DIV_W-1:0] v);
    return n ? -v : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage divider bus: opcode/operands/control in, stall/HI-LO write out.
interface div_unit_if;
  import div_unit_pkg::*;

  logic [7:0]       aluopE;
  logic [DIV_W-1:0] srcaE;
  logic [DIV_W-1:0] srcbE;
  logic             annulE;
  logic             stall_ext;
  logic             stall_div;
  logic             hilo_we;
  logic [DIV_W-1:0] hi_o;
  logic [DIV_W-1:0] lo_o;

  modport master (
    output aluopE, srcaE, srcbE, annulE, stall_ext,
    input  stall_div, hilo_we, hi_o, lo_o
  );

  modport slave (
    input  aluopE, srcaE, srcbE, annulE, stall_ext,
    output stall_div, hilo_we, hi_o, lo_o
  );

endinterface

// File: rtl/div_core.sv
// Unsigned restoring divider datapath: one quotient bit per cycle, DATA_W steps per division.
module div_core import div_unit_pkg::*; #(
  parameter int DATA_W = DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_last,
  output logic [DATA_W-1:0] o_quo_next,
  output logic [DATA_W-1:0] o_rem_next
);

  logic [DATA_W-1:0] r_rem, r_quo, r_div;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;

  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W-1:0] w_diff;
  logic              w_ge;

  // Shifted remainder can reach 2*divisor-1, so it keeps one extra bit for the compare.
  assign w_rem_sh   = {r_rem, r_quo[DATA_W-1]};
  assign w_ge       = w_rem_sh >= {1'b0, r_div};
  assign w_diff     = w_rem_sh[DATA_W-1:0] - r_div;
  assign o_rem_next = w_ge ? w_diff : w_rem_sh[DATA_W-1:0];
  assign o_quo_next = {r_quo[DATA_W-2:0], w_ge};
  assign o_last     = r_busy & (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_div  <= i_divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= o_rem_next;
      r_quo <= o_quo_next;
      r_cnt <= r_cnt + 1'b1;
      if (o_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Execute-stage DIV/DIVU unit: issue/busy/done FSM, sign handling, pipeline stall and HI/LO strobe.
module div_unit import div_unit_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  div_unit_if.slave    bus
);

  div_state_e       r_state, w_state_next;
  logic             r_q_neg, r_r_neg;
  logic [DIV_W-1:0] r_hi, r_lo;

  logic             w_is_signed, w_is_div, w_issue, w_div_zero;
  logic             w_a_neg, w_b_neg;
  logic [DIV_W-1:0] w_abs_a, w_abs_b, w_quo_next, w_rem_next;
  logic             w_core_start, w_core_clear, w_core_last;
  logic             w_stall_div, w_hilo_we;

  assign w_is_signed = bus.aluopE == EXE_DIV_OP;
  assign w_is_div    = w_is_signed | (bus.aluopE == EXE_DIVU_OP);
  assign w_issue     = (r_state == DIV_IDLE) & w_is_div & ~bus.annulE;
  assign w_div_zero  = bus.srcbE == '0;
  assign w_a_neg     = w_is_signed & bus.srcaE[DIV_W-1];
  assign w_b_neg     = w_is_signed & bus.srcbE[DIV_W-1];
  assign w_abs_a     = neg_if(w_a_neg, bus.srcaE);
  assign w_abs_b     = neg_if(w_b_neg, bus.srcbE);

  div_core #(.DATA_W(DIV_W)) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_core_clear),
    .i_start    (w_core_start),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_last     (w_core_last),
    .o_quo_next (w_quo_next),
    .o_rem_next (w_rem_next)
  );

  always_comb begin
    w_state_next = r_state;
    w_core_start = 1'b0;
    w_core_clear = 1'b0;
    w_stall_div  = 1'b0;
    w_hilo_we    = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (w_issue) begin
          w_stall_div = 1'b1;
          if (w_div_zero) begin
            w_state_next = DIV_DONE;
          end else begin
            w_core_start = 1'b1;
            w_state_next = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        w_stall_div = 1'b1;
        if (bus.annulE) begin
          w_core_clear = 1'b1;
          w_state_next = DIV_IDLE;
        end else if (w_core_last) begin
          w_state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        // E is released here; the write fires in the same cycle the instruction leaves E.
        if (bus.annulE) begin
          w_state_next = DIV_IDLE;
        end else if (!bus.stall_ext) begin
          w_hilo_we    = 1'b1;
          w_state_next = DIV_IDLE;
        end
      end
      default: w_state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) begin
        r_q_neg <= w_a_neg ^ w_b_neg;
        r_r_neg <= w_a_neg;
        if (w_div_zero) begin
          r_lo <= '1;
          r_hi <= bus.srcaE;
        end
      end else if (r_state == DIV_BUSY && !bus.annulE && w_core_last) begin
        r_lo <= neg_if(r_q_neg, w_quo_next);
        r_hi <= neg_if(r_r_neg, w_rem_next);
      end
    end
  end

  assign bus.stall_div = w_stall_div;
  assign bus.hilo_we   = w_hilo_we;
  assign bus.hi_o      = r_hi;
  assign bus.lo_o      = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latency, divide-by-zero, annul, external stall and reset.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam logic [7:0] NOP = 8'h00;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  div_unit_if bus();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a rising edge; returns in the cycle after the hilo_we pulse.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_lat);
    int stall_cyc;
    int n;
    bit got;
    stall_cyc = 0;
    n = 0;
    got = 1'b0;
    bus.aluopE = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
    while (!got && n < 100) begin
      @(negedge clk);
      if (bus.hilo_we) begin
        got = 1'b1;
      end else begin
        if (bus.stall_div) stall_cyc++;
        @(posedge clk);
        #1;
      end
      n++;
    end
    chk({tag, "_we"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, 32'(stall_cyc), 32'(exp_lat));
    chk({tag, "_lo"}, bus.lo_o, exp_lo);
    chk({tag, "_hi"}, bus.hi_o, exp_hi);
    $display("[TB] %s op=%h a=%h b=%h lo=%h hi=%h stall=%0d", tag, op, a, b,
             bus.lo_o, bus.hi_o, stall_cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    bus.aluopE = NOP;
    @(negedge clk);
    chk({tag, "_we"}, 32'(bus.hilo_we), 32'd0);
    chk({tag, "_stall"}, 32'(bus.stall_div), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int n;
    bit seen;

    rst           = 1'b1;
    bus.aluopE    = NOP;
    bus.srcaE     = '0;
    bus.srcbE     = '0;
    bus.annulE    = 1'b0;
    bus.stall_ext = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(bus.stall_div), 32'd0);
    chk("rst_we", 32'(bus.hilo_we), 32'd0);
    chk("rst_lo", bus.lo_o, 32'd0);
    chk("rst_hi", bus.hi_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_div("div_7_2", EXE_DIV_OP, 32'd7, 32'd2, 32'd3, 32'd1, 33);
    idle_check("div_7_2_post");
    run_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    idle_check("div_m7_2_post");
    run_div("divu_m7_2", EXE_DIVU_OP, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 33);
    idle_check("divu_m7_2_post");
    run_div("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    idle_check("div_7_m2_post");
    run_div("divu_by0", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    idle_check("divu_by0_post");
    run_div("div_by0", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);
    idle_check("div_by0_post");
    run_div("div_min_m1", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    idle_check("div_min_m1_post");

    // annul while idle must suppress the issue stall
    bus.aluopE = EXE_DIV_OP;
    bus.srcaE  = 32'd5;
    bus.srcbE  = 32'd1;
    bus.annulE = 1'b1;
    @(negedge clk);
    chk("annul_idle_stall", 32'(bus.stall_div), 32'd0);
    @(posedge clk);
    #1;
    bus.annulE = 1'b0;
    bus.aluopE = NOP;
    @(negedge clk);
    chk("annul_idle_next", 32'(bus.stall_div), 32'd0);
    @(posedge clk);
    #1;

    // annul at BUSY cycle 10
    bus.aluopE = EXE_DIV_OP;
    bus.srcaE  = 32'd1000;
    bus.srcbE  = 32'd3;
    @(posedge clk);
    #1;
    repeat (9) @(posedge clk);
    #1;
    bus.annulE = 1'b1;
    @(negedge clk);
    chk("annul_busy_we", 32'(bus.hilo_we), 32'd0);
    @(posedge clk);
    #1;
    bus.annulE = 1'b0;
    bus.aluopE = NOP;
    @(negedge clk);
    chk("annul_busy_stall", 32'(bus.stall_div), 32'd0);
    chk("annul_busy_lo_kept", bus.lo_o, 32'h8000_0000);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.hilo_we) pulses++;
    end
    chk("annul_no_we", 32'(pulses), 32'd0);
    $display("[TB] annul_busy stall=%0d we_pulses=%0d lo=%h", bus.stall_div, pulses, bus.lo_o);
    @(posedge clk);
    #1;
    run_div("div_100_7", EXE_DIV_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    idle_check("div_100_7_post");

    // external stall held for 5 DONE cycles
    bus.stall_ext = 1'b1;
    bus.aluopE    = EXE_DIV_OP;
    bus.srcaE     = 32'd7;
    bus.srcbE     = 32'd2;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (!bus.stall_div) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
      n++;
    end
    chk("ext_reach_done", 32'(seen), 32'd1);
    pulses = 0;
    repeat (5) begin
      if (bus.hilo_we) pulses++;
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    chk("ext_hold_we", 32'(pulses), 32'd0);
    @(posedge clk);
    #1;
    bus.stall_ext = 1'b0;
    @(negedge clk);
    chk("ext_release_we", 32'(bus.hilo_we), 32'd1);
    chk("ext_lo", bus.lo_o, 32'd3);
    chk("ext_hi", bus.hi_o, 32'd1);
    $display("[TB] stall_ext hold_pulses=%0d release_we=%0d lo=%h hi=%h", pulses, bus.hilo_we,
             bus.lo_o, bus.hi_o);
    @(posedge clk);
    #1;
    idle_check("ext_post");

    // reset in the middle of BUSY
    bus.aluopE = EXE_DIV_OP;
    bus.srcaE  = 32'd100;
    bus.srcbE  = 32'd7;
    repeat (6) @(posedge clk);
    #1;
    rst        = 1'b1;
    bus.aluopE = NOP;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_stall", 32'(bus.stall_div), 32'd0);
    chk("rst_busy_we", 32'(bus.hilo_we), 32'd0);
    chk("rst_busy_lo", bus.lo_o, 32'd0);
    chk("rst_busy_hi", bus.hi_o, 32'd0);
    $display("[TB] rst_busy stall=%0d we=%0d lo=%h hi=%h", bus.stall_div, bus.hilo_we,
             bus.lo_o, bus.hi_o);
    @(posedge clk);
    #1;

    run_div("b2b_div", EXE_DIV_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div("b2b_divu", EXE_DIVU_OP, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 33);
    idle_check("b2b_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
